// File: rtl/rgb_pwm_generator.sv
// rtl/rgb_pwm_generator.sv - three-channel PWM LED driver with period-boundary duty capture
module rgb_pwm_generator #(
    parameter int unsigned PRESCALE   = 100,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] R_time_in,
    input  logic [7:0] G_time_in,
    input  logic [7:0] B_time_in,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       period_done,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    state_t      r_state;
    logic [15:0] r_pre;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_sh_r;
    logic [7:0]  r_sh_g;
    logic [7:0]  r_sh_b;

    logic w_tick;
    logic w_wrap;

    assign w_tick = (r_pre == PRE_MAX);
    assign w_wrap = w_tick && (r_pwm_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_pwm_cnt   <= '0;
            r_sh_r      <= '0;
            r_sh_g      <= '0;
            r_sh_b      <= '0;
            led_r       <= ACTIVE_LOW;
            led_g       <= ACTIVE_LOW;
            led_b       <= ACTIVE_LOW;
            period_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            period_done <= 1'b0;
            led_r       <= ACTIVE_LOW;
            led_g       <= ACTIVE_LOW;
            led_b       <= ACTIVE_LOW;
            case (r_state)
                S_IDLE: begin
                    r_pre     <= '0;
                    r_pwm_cnt <= '0;
                    if (en) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_sh_r    <= R_time_in;
                    r_sh_g    <= G_time_in;
                    r_sh_b    <= B_time_in;
                    r_pre     <= '0;
                    r_pwm_cnt <= '0;
                    r_state   <= S_RUN;
                    busy      <= 1'b1;
                end
                S_RUN: begin
                    led_r <= (r_pwm_cnt < r_sh_r) ^ ACTIVE_LOW;
                    led_g <= (r_pwm_cnt < r_sh_g) ^ ACTIVE_LOW;
                    led_b <= (r_pwm_cnt < r_sh_b) ^ ACTIVE_LOW;
                    if (w_tick) begin
                        r_pre <= '0;
                        if (w_wrap) begin
                            r_pwm_cnt   <= '0;
                            period_done <= 1'b1;
                            // New colour is only taken at the boundary; a stop still finishes this period
                            if (en) begin
                                r_sh_r <= R_time_in;
                                r_sh_g <= G_time_in;
                                r_sh_b <= B_time_in;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_pwm_cnt <= r_pwm_cnt + 8'd1;
                        end
                    end else begin
                        r_pre <= r_pre + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
